// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline event inputs and register-control outputs of the hazard controller
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             ihit;
  logic             memDREN;
  logic             memDWEN;
  logic             dhit;
  logic             memBrTaken;
  logic             memHalt;
  logic             exDREN;
  logic [4:0]       exDest;
  logic [4:0]       idRs;
  logic [4:0]       idRt;
  logic             idUsesRt;
  logic             pcW;
  logic             ifidW;
  logic             idexW;
  logic             exmemW;
  logic             memwbW;
  logic             ifidFlush;
  logic             idexFlush;
  logic             exmemFlush;
  logic             halted;
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;

  // master: the datapath that raises events and consumes the controls
  modport master (
    output ihit, memDREN, memDWEN, dhit, memBrTaken, memHalt,
           exDREN, exDest, idRs, idRt, idUsesRt,
    input  pcW, ifidW, idexW, exmemW, memwbW,
           ifidFlush, idexFlush, exmemFlush, halted, stallCnt, flushCnt
  );

  modport slave (
    input  ihit, memDREN, memDWEN, dhit, memBrTaken, memHalt,
           exDREN, exDest, idRs, idRt, idUsesRt,
    output pcW, ifidW, idexW, exmemW, memwbW,
           ifidFlush, idexFlush, exmemFlush, halted, stallCnt, flushCnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline stall/flush arbiter with halt latch and perf counters
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic          CLK,
  input  logic          RST,
  hazard_ctrl_if.slave  hif
);
  typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic       dmem_wait;
  logic       load_use;
  // write enables packed as {pc, ifid, idex, exmem, memwb}; flushes as {ifid, idex, exmem}
  logic [4:0] r_w, w;
  logic [2:0] r_fl, fl;
  logic       r_halt, r_br, br_evt;

  assign dmem_wait = (hif.memDREN | hif.memDWEN) & ~hif.dhit;
  assign load_use  = hif.exDREN && (hif.exDest != 5'd0) &&
                     ((hif.exDest == hif.idRs) || (hif.idUsesRt && (hif.exDest == hif.idRt)));

  // Resolution of everything below the dcache wait; shared by RUN and DWAIT exit.
  always_comb begin
    r_w    = 5'b11111;
    r_fl   = 3'b000;
    r_halt = 1'b0;
    r_br   = 1'b0;
    if (hif.memHalt) begin
      r_w    = 5'b00001;
      r_halt = 1'b1;
    end else if (hif.memBrTaken) begin
      r_fl = 3'b111;
      r_br = 1'b1;
    end else if (load_use || !hif.ihit) begin
      r_w  = 5'b00111;
      r_fl = 3'b010;
    end
  end

  always_comb begin
    state_d = state_q;
    w       = 5'b00000;
    fl      = 3'b000;
    br_evt  = 1'b0;
    case (state_q)
      RUN: begin
        if (dmem_wait) begin
          state_d = DWAIT;
        end else begin
          w       = r_w;
          fl      = r_fl;
          br_evt  = r_br;
          state_d = r_halt ? HALT : RUN;
        end
      end
      DWAIT: begin
        if (hif.dhit) begin
          w       = r_w;
          fl      = r_fl;
          br_evt  = r_br;
          state_d = r_halt ? HALT : RUN;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
    if (RST) begin
      state_d = RUN;
      w       = 5'b00000;
      fl      = 3'b000;
      br_evt  = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!RST && !w[4] && (state_q != HALT) && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    if (br_evt && !(&flush_cnt_q))
      flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign {hif.pcW, hif.ifidW, hif.idexW, hif.exmemW, hif.memwbW} = w;
  assign {hif.ifidFlush, hif.idexFlush, hif.exmemFlush}          = fl;
  assign hif.halted   = (state_q == HALT) && !RST;
  assign hif.stallCnt = stall_cnt_q;
  assign hif.flushCnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - table-driven check of hazard_ctrl with narrow counters to reach saturation
module tb_hazard_ctrl;
  localparam int CW = 4;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  hazard_ctrl_if #(.CNT_W(CW)) hif ();
  hazard_ctrl #(.CNT_W(CW)) dut (.CLK(CLK), .RST(RST), .hif(hif));

  typedef struct {
    logic          rst, ihit, drd, dwr, dhit, br, hlt, exrd, urt;
    logic [4:0]    dest, rs, rt;
    logic [4:0]    ew;
    logic [2:0]    ef;
    logic          eh;
    logic [CW-1:0] es, efc;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t v(input logic rst, ihit, drd, dwr, dhit, br, hlt, exrd,
                             input logic [4:0] dest, rs, rt, input logic urt,
                             input logic [4:0] ew, input logic [2:0] ef, input logic eh,
                             input int es, efc);
    vec_t t;
    t.rst = rst; t.ihit = ihit; t.drd = drd; t.dwr = dwr; t.dhit = dhit;
    t.br = br; t.hlt = hlt; t.exrd = exrd; t.dest = dest; t.rs = rs; t.rt = rt;
    t.urt = urt; t.ew = ew; t.ef = ef; t.eh = eh;
    t.es = es[CW-1:0]; t.efc = efc[CW-1:0];
    return t;
  endfunction

  function automatic vec_t idle(input logic [4:0] ew, input logic eh, input int es, efc);
    return v(0,1,0,0,0,0,0,0, 0,0,0,0, ew, 3'b000, eh, es, efc);
  endfunction

  task automatic step(input vec_t t, input string tag);
    logic [4:0]    aw;
    logic [2:0]    af;
    RST           = t.rst;
    hif.ihit      = t.ihit;
    hif.memDREN   = t.drd;
    hif.memDWEN   = t.dwr;
    hif.dhit      = t.dhit;
    hif.memBrTaken = t.br;
    hif.memHalt   = t.hlt;
    hif.exDREN    = t.exrd;
    hif.exDest    = t.dest;
    hif.idRs      = t.rs;
    hif.idRt      = t.rt;
    hif.idUsesRt  = t.urt;
    #4;
    aw = {hif.pcW, hif.ifidW, hif.idexW, hif.exmemW, hif.memwbW};
    af = {hif.ifidFlush, hif.idexFlush, hif.exmemFlush};
    n_checks++;
    if (aw !== t.ew || af !== t.ef || hif.halted !== t.eh ||
        hif.stallCnt !== t.es || hif.flushCnt !== t.efc) begin
      n_errors++;
      $display("FAIL %s: got w=%b fl=%b halted=%b stall=%0d flush=%0d, want w=%b fl=%b halted=%b stall=%0d flush=%0d",
               tag, aw, af, hif.halted, hif.stallCnt, hif.flushCnt,
               t.ew, t.ef, t.eh, t.es, t.efc);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    hif.ihit = 1'b1; hif.memDREN = 0; hif.memDWEN = 0; hif.dhit = 0;
    hif.memBrTaken = 0; hif.memHalt = 0; hif.exDREN = 0;
    hif.exDest = 0; hif.idRs = 0; hif.idRt = 0; hif.idUsesRt = 0;
    @(posedge CLK);
    #1;

    //                 rst ihit drd dwr dhit br hlt exrd dest rs rt urt  ew      ef    eh  s  fc
    vecs.push_back(v(1,1,0,0,0,0,0,0, 0,0,0,0, 5'b00000,3'b000,0, 0,0));  // 0 in reset
    vecs.push_back(idle(5'b11111,0,0,0));                                  // 1
    vecs.push_back(idle(5'b11111,0,0,0));                                  // 2
    vecs.push_back(v(0,1,0,0,0,0,0,1, 5,5,0,0, 5'b00111,3'b010,0, 0,0));  // 3 load-use rs
    vecs.push_back(idle(5'b11111,0,1,0));                                  // 4
    vecs.push_back(v(0,1,0,0,0,0,0,1, 0,0,0,1, 5'b11111,3'b000,0, 1,0));  // 5 r0 never hazards
    vecs.push_back(v(0,1,0,0,0,0,0,1, 5,3,5,0, 5'b11111,3'b000,0, 1,0));  // 6 rt unused
    vecs.push_back(v(0,1,0,0,0,0,0,1, 5,3,5,1, 5'b00111,3'b010,0, 1,0));  // 7 load-use rt
    vecs.push_back(idle(5'b11111,0,2,0));                                  // 8
    vecs.push_back(v(0,0,0,0,0,0,0,0, 0,0,0,0, 5'b00111,3'b010,0, 2,0));  // 9 imem wait
    vecs.push_back(idle(5'b11111,0,3,0));                                  // 10
    vecs.push_back(v(0,1,1,0,0,0,0,0, 0,0,0,0, 5'b00000,3'b000,0, 3,0));  // 11 dmem wait
    vecs.push_back(v(0,1,1,0,0,0,0,0, 0,0,0,0, 5'b00000,3'b000,0, 4,0));  // 12
    vecs.push_back(v(0,1,1,0,0,0,0,0, 0,0,0,0, 5'b00000,3'b000,0, 5,0));  // 13
    vecs.push_back(v(0,1,1,0,1,0,0,0, 0,0,0,0, 5'b11111,3'b000,0, 6,0));  // 14 dhit
    vecs.push_back(idle(5'b11111,0,6,0));                                  // 15
    vecs.push_back(v(0,1,0,1,0,0,0,0, 0,0,0,0, 5'b00000,3'b000,0, 6,0));  // 16 store wait
    vecs.push_back(v(0,1,0,1,1,1,0,0, 0,0,0,0, 5'b11111,3'b111,0, 7,0));  // 17 branch on exit
    vecs.push_back(idle(5'b11111,0,7,1));                                  // 18
    vecs.push_back(v(0,0,0,0,0,1,0,1, 5,5,0,0, 5'b11111,3'b111,0, 7,1));  // 19 branch beats load-use
    vecs.push_back(idle(5'b11111,0,7,2));                                  // 20
    vecs.push_back(v(0,1,1,0,0,1,0,0, 0,0,0,0, 5'b00000,3'b000,0, 7,2));  // 21 dwait beats branch
    vecs.push_back(v(0,1,1,0,0,0,0,0, 0,0,0,0, 5'b00000,3'b000,0, 8,2));  // 22
    vecs.push_back(v(0,1,1,0,1,0,0,1, 5,5,0,0, 5'b00111,3'b010,0, 9,2));  // 23 load-use on exit
    vecs.push_back(idle(5'b11111,0,10,2));                                 // 24
    vecs.push_back(v(0,1,1,0,0,0,0,0, 0,0,0,0, 5'b00000,3'b000,0, 10,2)); // 25 into DWAIT
    vecs.push_back(v(1,1,1,0,0,0,0,0, 0,0,0,0, 5'b00000,3'b000,0, 11,2)); // 26 reset in DWAIT
    vecs.push_back(idle(5'b11111,0,0,0));                                  // 27 back in RUN
    vecs.push_back(v(0,1,1,0,0,0,1,0, 0,0,0,0, 5'b00000,3'b000,0, 0,0));  // 28 dwait beats halt
    vecs.push_back(v(0,1,1,0,1,0,1,0, 0,0,0,0, 5'b00001,3'b000,0, 1,0));  // 29 halt on exit
    vecs.push_back(idle(5'b00000,1,2,0));                                  // 30 halted
    vecs.push_back(v(0,1,0,0,0,1,0,0, 0,0,0,0, 5'b00000,3'b000,1, 2,0));  // 31 branch ignored

    foreach (vecs[i]) step(vecs[i], $sformatf("row%0d", i));

    for (int i = 0; i < 10; i++) step(idle(5'b00000,1,2,0), $sformatf("halt_hold%0d", i));
    step(v(1,1,0,0,0,0,0,0, 0,0,0,0, 5'b00000,3'b000,0, 2,0), "halt_rst");
    step(idle(5'b11111,0,0,0), "after_halt_rst");

    step(v(0,1,0,0,0,1,1,0, 0,0,0,0, 5'b00001,3'b000,0, 0,0), "halt_beats_branch");
    step(idle(5'b00000,1,1,0), "halted_from_run");
    step(v(1,1,0,0,0,0,0,0, 0,0,0,0, 5'b00000,3'b000,0, 1,0), "rst2");

    for (int i = 0; i < 20; i++)
      step(v(0,0,0,0,0,0,0,0, 0,0,0,0, 5'b00111,3'b010,0, (i > 15) ? 15 : i, 0),
           $sformatf("stall_sat%0d", i));
    step(idle(5'b11111,0,15,0), "stall_sat_hold");
    step(v(1,1,0,0,0,0,0,0, 0,0,0,0, 5'b00000,3'b000,0, 15,0), "rst3");

    for (int i = 0; i < 20; i++)
      step(v(0,1,0,0,0,1,0,0, 0,0,0,0, 5'b11111,3'b111,0, 0, (i > 15) ? 15 : i),
           $sformatf("flush_sat%0d", i));
    step(idle(5'b11111,0,0,15), "flush_sat_hold");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
